// File: rtl/serial_tx_pkg.sv
// Shared types and helpers for the serial byte transmitter.
package serial_tx_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_e;

    // Counter width for a modulus of v, never narrower than one bit.
    function automatic int clog2w(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/serial_tx_8bit_tick.sv
// Cycle divider: ticks on the last cycle of each CYCLES-long period.
module bit_tick_gen
    import serial_tx_pkg::*;
#(
    parameter int CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int W = clog2w(CYCLES);
    localparam logic [W-1:0] LAST = W'(CYCLES - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_tx_8bit.sv
// Parallel-in serial-out transmitter with per-bit hold time and
// optional inter-frame gap.
module serial_tx_8bit
    import serial_tx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 1,
    parameter int GAP_CYCLES = 0,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              ser_first,
    output logic              ser_last,
    output logic              busy,
    output logic              frame_done
);

    if (DATA_W < 2 || BIT_CYCLES < 1) begin : g_bad_params
        $fatal(1, "serial_tx_8bit: DATA_W must be >= 2, BIT_CYCLES >= 1");
    end

    localparam int IW    = clog2w(DATA_W);
    localparam int GAP_N = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

    state_e            state_q;
    logic [DATA_W-1:0] sh_q;
    logic [IW-1:0]     idx_q;
    logic              so_q;
    logic              sv_q;
    logic              sf_q;
    logic              sl_q;
    logic              fd_q;
    logic              bit_tick;
    logic              gap_tick;

    function automatic logic head(input logic [DATA_W-1:0] x);
        return MSB_FIRST ? x[DATA_W-1] : x[0];
    endfunction

    function automatic logic [DATA_W-1:0] shift(input logic [DATA_W-1:0] x);
        return MSB_FIRST ? {x[DATA_W-2:0], 1'b0} : {1'b0, x[DATA_W-1:1]};
    endfunction

    bit_tick_gen #(.CYCLES(BIT_CYCLES)) u_bit_tick (
        .clk     (clk),
        .rst     (rst),
        .clear_i (state_q != S_SHIFT),
        .en_i    (state_q == S_SHIFT),
        .tick_o  (bit_tick)
    );

    // Same divider, reused as the inter-frame gap countdown.
    bit_tick_gen #(.CYCLES(GAP_N)) u_gap_tick (
        .clk     (clk),
        .rst     (rst),
        .clear_i (state_q != S_GAP),
        .en_i    (state_q == S_GAP),
        .tick_o  (gap_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            idx_q   <= '0;
            so_q    <= 1'b0;
            sv_q    <= 1'b0;
            sf_q    <= 1'b0;
            sl_q    <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            fd_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        sh_q    <= data_in;
                        idx_q   <= '0;
                        so_q    <= head(data_in);
                        sv_q    <= 1'b1;
                        sf_q    <= 1'b1;
                        sl_q    <= 1'b0;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (bit_tick) begin
                        if (idx_q == IDX_LAST) begin
                            so_q    <= 1'b0;
                            sv_q    <= 1'b0;
                            sf_q    <= 1'b0;
                            sl_q    <= 1'b0;
                            fd_q    <= 1'b1;
                            state_q <= (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                        end else begin
                            sh_q  <= shift(sh_q);
                            idx_q <= idx_q + 1'b1;
                            so_q  <= head(shift(sh_q));
                            sf_q  <= 1'b0;
                            sl_q  <= ((idx_q + 1'b1) == IDX_LAST);
                        end
                    end
                end
                S_GAP: begin
                    if (gap_tick) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign ser_out    = so_q;
    assign ser_valid  = sv_q;
    assign ser_first  = sf_q;
    assign ser_last   = sl_q;
    assign frame_done = fd_q;

endmodule
